// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - video, CPU and RAM signal bundle around the VRAM arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  logic              starve_err;

  // master is the arbiter itself; slave is the video/CPU/RAM side
  modport master (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, cpu_ack, cpu_rdata, ram_addr, ram_wdata, ram_we, starve_err
  );

  modport slave (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, cpu_ack, cpu_rdata, ram_addr, ram_wdata, ram_we, starve_err
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: video has absolute priority, CPU served in gaps
module vram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 7
) (
  input logic            clk_25,
  input logic            reset_n,
  vram_arbiter_if.master bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t state, state_nxt;
  tag_t   tag_s1, tag_s2, tag_s3;
  logic   rd_s1, rd_s2;
  logic [3:0] wait_cnt, wait_nxt;
  logic   issue_vid, issue_cpu, cpu_blocked;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ack_q;
  logic              starve_err_q;

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.vid_data   = vid_data_q;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.starve_err = starve_err_q;

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue_vid   = bus.vid_req;
    issue_cpu   = 1'b0;
    cpu_blocked = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          if (bus.vid_req) begin
            cpu_blocked = 1'b1;
          end else begin
            issue_cpu = 1'b1;
            state_nxt = S_BUSY;
          end
        end
      end
      // the stage-3 CPU tag coincides with the cpu_ack pulse
      S_BUSY:  if (tag_s3 == TAG_CPU) state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    wait_nxt = wait_cnt;
    if (issue_cpu)                             wait_nxt = 4'd0;
    else if (cpu_blocked && wait_cnt != 4'hF)  wait_nxt = wait_cnt + 4'd1;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      tag_s1       <= TAG_NONE;
      tag_s2       <= TAG_NONE;
      tag_s3       <= TAG_NONE;
      rd_s1        <= 1'b0;
      rd_s2        <= 1'b0;
      wait_cnt     <= 4'd0;
      starve_err_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      vid_data_q   <= '0;
      vid_valid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (cpu_blocked && int'(wait_nxt) >= MAX_WAIT) starve_err_q <= 1'b1;

      // issue stage: address stays put on idle cycles, only CPU writes raise ram_we
      ram_we_q <= 1'b0;
      if (issue_vid) begin
        ram_addr_q <= bus.vid_addr;
      end else if (issue_cpu) begin
        ram_addr_q  <= bus.cpu_addr;
        ram_wdata_q <= bus.cpu_wdata;
        ram_we_q    <= bus.cpu_we;
      end

      tag_s1 <= issue_vid ? TAG_VID : (issue_cpu ? TAG_CPU : TAG_NONE);
      rd_s1  <= issue_cpu && !bus.cpu_we;
      tag_s2 <= tag_s1;
      rd_s2  <= rd_s1;
      tag_s3 <= tag_s2;

      // stage 2 is the cycle ram_rdata holds the word for this access
      vid_valid_q <= (tag_s2 == TAG_VID);
      if (tag_s2 == TAG_VID) vid_data_q <= bus.ram_rdata;
      cpu_ack_q <= (tag_s2 == TAG_CPU);
      if (tag_s2 == TAG_CPU && rd_s2) cpu_rdata_q <= bus.ram_rdata;
    end
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, VRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, VRAM data width.
REQ-003 SHALL have parameter MAX_WAIT, default 7, CPU wait-cycle limit before starvation flag.
REQ-004 SHALL have port clk_25  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port vid_req  input  1  one-cycle video fetch strobe (display controller pixel-advance slot).
REQ-007 SHALL have port vid_addr  input  ADDR_W  video fetch address, valid with vid_req.
REQ-008 SHALL have ports vid_data  output  DATA_W  fetched byte, and vid_valid  output  1  one-cycle pulse when vid_data updates.
REQ-009 SHALL have ports cpu_req  input  1  level request, held until ack; cpu_we  input  1  write; cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W.
REQ-010 SHALL have ports cpu_ack  output  1  one-cycle completion pulse, and cpu_rdata  output  DATA_W  read data, valid with cpu_ack.
REQ-011 SHALL have ports ram_addr  output  ADDR_W, ram_wdata  output  DATA_W, ram_we  output  1, ram_rdata  input  DATA_W; RAM is synchronous single-port with 1-cycle read latency.
REQ-012 SHALL have port starve_err  output  1  sticky CPU starvation flag.

Function
REQ-013 SHALL give video absolute priority: vid_req high in cycle N always issues the video access in cycle N, regardless of CPU state.
REQ-014 SHALL register the decision of cycle N onto ram_addr/ram_wdata/ram_we at the edge ending N; RAM samples at edge ending N+1; ram_rdata captured at edge ending N+2.
REQ-015 SHALL present video data on vid_data with vid_valid pulsed in cycle N+3 for vid_req in cycle N; vid_data SHALL hold until the next video capture.
REQ-016 SHALL carry a 3-stage owner tag pipeline (NONE/VID/CPU) alongside each access so captured ram_rdata routes to the correct requester.
REQ-017 SHALL implement CPU FSM: IDLE, BUSY, HOLD.
REQ-018 IDLE: cpu_req=1 and vid_req=0 -> issue CPU access (ram_we=cpu_we), go BUSY; cpu_req=1 and vid_req=1 -> stay IDLE, increment wait counter.
REQ-019 BUSY: when the CPU tag reaches stage 3 (cycle N+3), pulse cpu_ack for one cycle (cpu_rdata loaded from ram_rdata on reads, unchanged on writes), go HOLD.
REQ-020 HOLD: ignore cpu_req for one cycle, go IDLE; requester SHALL have dropped cpu_req by then, else a new access starts from IDLE.
REQ-021 SHALL drive ram_we=1 only for a CPU write issue cycle; video issues and idle cycles SHALL drive ram_we=0, ram_addr held at last value.
REQ-022 Wait counter: 4-bit, saturating at 15, cleared on every CPU issue; reaching MAX_WAIT SHALL set starve_err, which stays set until reset.
REQ-023 Simultaneous vid_req and CPU issue eligibility SHALL resolve to video; vid_req arriving while CPU is BUSY SHALL be issued normally (pipelined, no conflict).
REQ-024 Back-to-back vid_req on consecutive cycles SHALL each be served, each with its own vid_valid pulse 3 cycles later.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: FSM IDLE, tags NONE, wait counter 0, starve_err 0, cpu_ack 0, vid_valid 0, ram_we 0, ram_addr 0, ram_wdata 0, vid_data 0, cpu_rdata 0.
REQ-026 Reset during BUSY SHALL abandon the access with no cpu_ack issued; in-flight video data SHALL be discarded.

Verification
REQ-027 Video only: vid_req with vid_addr=0x123 at cycle 0, RAM holds 0x5A -> ram_addr=0x123 cycle 1, vid_valid=1 and vid_data=0x5A cycle 3.
REQ-028 CPU write then read: cpu_we=1, addr=0x040, wdata=0xC3, no video -> ram_we=1 cycle 1, cpu_ack cycle 3; read same addr -> cpu_rdata=0xC3 with cpu_ack.
REQ-029 Collision: cpu_req and vid_req both at cycle 0, vid_req pattern 2-of-5 -> video issued cycle 0, CPU issued cycle 1, cpu_ack cycle 4, vid_valid cycle 3.
REQ-030 Starvation: cpu_req held with vid_req=1 continuously for 8 cycles -> starve_err=1 at count 7, remains 1 after vid_req drops and CPU completes.
REQ-031 Reset mid-operation: reset_n low during BUSY -> all outputs zero immediately, no cpu_ack after release; fresh request completes with normal 3-cycle latency.
